// File: rtl/async_fifo_rptr_empty_if.sv
// Read-side consumer handshake of the dual-clock FIFO: FWFT data word with valid/ready.
interface async_fifo_rptr_empty_if #(
    parameter int DATASIZE = 8
);
    logic [DATASIZE-1:0] rdata;
    logic                rvalid;
    logic                rready;

    modport master (output rdata, output rvalid, input rready);
    modport slave  (input rdata, input rvalid, output rready);
endinterface

// File: rtl/async_fifo_rptr_empty.sv
// Read-domain control of the dual-clock FIFO: wptr synchroniser, Gray read pointer,
// registered empty, fill level / almost-empty and a first-word-fall-through output register.
module async_fifo_rptr_empty #(
    parameter int ADDRSIZE      = 4,
    parameter int DATASIZE      = 8,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                    rclk,
    input  logic                    rrst,
    input  logic [ADDRSIZE:0]       wptr,
    output logic [ADDRSIZE:0]       rptr,
    output logic [ADDRSIZE-1:0]     raddr,
    input  logic [DATASIZE-1:0]     mem_rdata,
    async_fifo_rptr_empty_if.master rd,
    output logic                    rempty,
    output logic [ADDRSIZE:0]       rlevel,
    output logic                    ralmost_empty
);
    localparam logic [ADDRSIZE:0] AE_LEVEL = (ADDRSIZE+1)'(AEMPTY_THRESH);

    function automatic logic [ADDRSIZE:0] bin2gray(input logic [ADDRSIZE:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDRSIZE:0] rq1_wptr;
    logic [ADDRSIZE:0] rq2_wptr;
    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] rbinnext;
    logic [ADDRSIZE:0] rgraynext;
    logic              rempty_val;
    logic              pop;

    // A word leaves storage whenever one exists and the output register is free or being drained.
    assign pop        = ~rempty & (~rd.rvalid | rd.rready);
    assign rbinnext   = rbin + {{ADDRSIZE{1'b0}}, pop};
    assign rgraynext  = bin2gray(rbinnext);
    assign rempty_val = (rgraynext == rq2_wptr);
    assign raddr      = rbin[ADDRSIZE-1:0];

    assign rlevel        = gray2bin(rq2_wptr) - rbin;
    assign ralmost_empty = (rlevel <= AE_LEVEL);

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rq1_wptr  <= '0;
            rq2_wptr  <= '0;
            rbin      <= '0;
            rptr      <= '0;
            rempty    <= 1'b1;
            rd.rdata  <= '0;
            rd.rvalid <= 1'b0;
        end else begin
            {rq2_wptr, rq1_wptr} <= {rq1_wptr, wptr};
            rbin   <= rbinnext;
            rptr   <= rgraynext;
            rempty <= rempty_val;
            if (pop) begin
                rd.rdata  <= mem_rdata;
                rd.rvalid <= 1'b1;
            end else if (rd.rvalid && rd.rready) begin
                rd.rvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_async_fifo_rptr_empty.sv
// Bench for async_fifo_rptr_empty: vector table, directed sequences and random streaming vs a count/queue model.
module tb_async_fifo_rptr_empty;
    logic       rclk = 1'b0;
    logic       rrst = 1'b1;
    logic [4:0] wptr = '0;
    logic [4:0] rptr;
    logic [3:0] raddr;
    logic [7:0] mem_rdata;
    logic       rempty;
    logic [4:0] rlevel;
    logic       ralmost_empty;

    async_fifo_rptr_empty_if #(.DATASIZE(8)) rd_if ();

    async_fifo_rptr_empty #(.ADDRSIZE(4), .DATASIZE(8), .AEMPTY_THRESH(2)) dut (
        .rclk          (rclk),
        .rrst          (rrst),
        .wptr          (wptr),
        .rptr          (rptr),
        .raddr         (raddr),
        .mem_rdata     (mem_rdata),
        .rd            (rd_if.master),
        .rempty        (rempty),
        .rlevel        (rlevel),
        .ralmost_empty (ralmost_empty)
    );

    always #5 rclk = ~rclk;

    logic [7:0] mem [16];
    assign mem_rdata = mem[raddr];

    int errors = 0;
    int checks = 0;

    // Writer side and reference model state (counts, not pointers).
    int         wcnt = 0;
    logic [7:0] dq[$];
    logic [7:0] sent[$];
    logic [7:0] consumed[$];
    int         m_rq1, m_rq2, m_rd;
    logic       m_empty, m_valid;
    logic [7:0] m_data;
    bit         wrapped;

    typedef struct {
        logic       rst;
        logic       push;
        logic [7:0] wdata;
        logic       ready;
        logic       e_empty;
        logic       e_valid;
        logic [7:0] e_data;
        logic [4:0] e_rptr;
        logic [4:0] e_level;
        logic       e_ae;
    } vec_t;
    vec_t tbl[9];

    function automatic logic [4:0] to_gray(input int n);
        logic [4:0] b;
        b = 5'(n % 32);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [7:0] v);
        mem[wcnt % 16] = v;
        dq.push_back(v);
        sent.push_back(v);
        wcnt++;
        wptr = to_gray(wcnt);
    endtask

    task automatic model_step();
        bit pop;
        if (rrst) begin
            m_rq1 = 0; m_rq2 = 0; m_rd = 0;
            m_empty = 1'b1; m_valid = 1'b0; m_data = 8'h00;
        end else begin
            pop = !m_empty && (!m_valid || rd_if.rready);
            if (pop) begin
                m_data  = (dq.size() > 0) ? dq.pop_front() : 8'hxx;
                m_valid = 1'b1;
                m_rd++;
            end else if (m_valid && rd_if.rready) begin
                m_valid = 1'b0;
            end
            m_empty = ((m_rd % 32) == m_rq2);
            m_rq2   = m_rq1;
            m_rq1   = wcnt % 32;
        end
    endtask

    task automatic tick();
        logic [4:0] prev;
        int         lvl;
        prev = rptr;
        if (!rrst && rd_if.rvalid === 1'b1 && rd_if.rready) consumed.push_back(rd_if.rdata);
        model_step();
        @(posedge rclk);
        #1;
        lvl = (m_rq2 - (m_rd % 32) + 32) % 32;
        chk("rempty", 32'(rempty), 32'(m_empty));
        chk("rvalid", 32'(rd_if.rvalid), 32'(m_valid));
        chk("rdata", 32'(rd_if.rdata), 32'(m_data));
        chk("rptr", 32'(rptr), 32'(to_gray(m_rd)));
        chk("raddr", 32'(raddr), 32'(m_rd % 16));
        chk("rlevel", 32'(rlevel), 32'(lvl));
        chk("ralmost_empty", 32'(ralmost_empty), 32'(lvl <= 2));
        if (!rrst && rptr !== prev) begin
            chk("gray_one_bit", 32'($countones(rptr ^ prev)), 32'd1);
            if (prev == 5'b10000 && rptr == 5'b00000) wrapped = 1'b1;
        end
    endtask

    task automatic clear_writer();
        wcnt = 0;
        wptr = '0;
        dq.delete();
        sent.delete();
        consumed.delete();
    endtask

    task automatic do_reset();
        rrst = 1'b1;
        rd_if.rready = 1'b0;
        clear_writer();
        tick();
        tick();
        rrst = 1'b0;
    endtask

    initial begin
        rd_if.rready = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        //          rst push data  rdy  emp vld data   rptr     lvl    ae
        tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 5'b00000, 5'd0, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 5'b00000, 5'd0, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 5'b00000, 5'd0, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 5'b00000, 5'd1, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 5'b00000, 5'd1, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 5'b00001, 5'd0, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 5'b00001, 5'd0, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 5'b00001, 5'd0, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 5'b00001, 5'd0, 1'b1};

        // Reset and single-word fall-through.
        for (int i = 0; i < 9; i++) begin
            rrst = tbl[i].rst;
            rd_if.rready = tbl[i].ready;
            if (tbl[i].rst) clear_writer();
            if (tbl[i].push) push_word(tbl[i].wdata);
            tick();
            chk($sformatf("tbl%0d_rempty", i), 32'(rempty), 32'(tbl[i].e_empty));
            chk($sformatf("tbl%0d_rvalid", i), 32'(rd_if.rvalid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_rdata", i), 32'(rd_if.rdata), 32'(tbl[i].e_data));
            chk($sformatf("tbl%0d_rptr", i), 32'(rptr), 32'(tbl[i].e_rptr));
            chk($sformatf("tbl%0d_rlevel", i), 32'(rlevel), 32'(tbl[i].e_level));
            chk($sformatf("tbl%0d_ae", i), 32'(ralmost_empty), 32'(tbl[i].e_ae));
        end

        // Full burst: 16 words visible at once, drained one per cycle.
        do_reset();
        rd_if.rready = 1'b1;
        for (int i = 0; i < 16; i++) push_word(8'(i));
        tick();
        tick();
        chk("burst_level16", 32'(rlevel), 32'd16);
        begin
            int budget = 0;
            while (consumed.size() < 1 && budget < 10) begin
                tick();
                budget++;
            end
        end
        chk("burst_first_seen", 32'(consumed.size()), 32'd1);
        for (int i = 0; i < 15; i++) tick();
        chk("burst_throughput", 32'(consumed.size()), 32'd16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("burst_word%0d", i),
                32'((i < consumed.size()) ? consumed[i] : 8'hxx), 32'(i));
        chk("burst_rptr", 32'(rptr), 32'b11000);
        chk("burst_rempty", 32'(rempty), 32'd1);

        // Backpressure: first word held, then one word per ready cycle.
        do_reset();
        push_word(8'h31); tick();
        push_word(8'h32); tick();
        push_word(8'h33); tick();
        for (int i = 0; i < 8; i++) tick();
        chk("bp_rvalid", 32'(rd_if.rvalid), 32'd1);
        chk("bp_rdata_held", 32'(rd_if.rdata), 32'h31);
        chk("bp_rlevel", 32'(rlevel), 32'd2);
        rd_if.rready = 1'b1; tick();
        chk("bp_consumed1", 32'(consumed.size()), 32'd1);
        rd_if.rready = 1'b0; tick();
        chk("bp_consumed1_hold", 32'(consumed.size()), 32'd1);
        rd_if.rready = 1'b1; tick();
        rd_if.rready = 1'b0;
        chk("bp_consumed2", 32'(consumed.size()), 32'd2);
        chk("bp_order0", 32'((consumed.size() > 0) ? consumed[0] : 8'hxx), 32'h31);
        chk("bp_order1", 32'((consumed.size() > 1) ? consumed[1] : 8'hxx), 32'h32);
        chk("bp_next_word", 32'(rd_if.rdata), 32'h33);

        // Almost-empty edge, then reset with words in flight.
        do_reset();
        for (int i = 0; i < 4; i++) push_word(8'h50 + 8'(i));
        for (int i = 0; i < 5; i++) tick();
        chk("ae_level3", 32'(rlevel), 32'd3);
        chk("ae_low_at3", 32'(ralmost_empty), 32'd0);
        rd_if.rready = 1'b1; tick();
        rd_if.rready = 1'b0;
        chk("ae_level2", 32'(rlevel), 32'd2);
        chk("ae_high_at2", 32'(ralmost_empty), 32'd1);
        for (int i = 0; i < 3; i++) push_word(8'h60 + 8'(i));
        for (int i = 0; i < 4; i++) tick();
        chk("midrst_pre_valid", 32'(rd_if.rvalid), 32'd1);
        chk("midrst_pre_level", 32'(rlevel), 32'd5);
        rrst = 1'b1;
        clear_writer();
        tick();
        rrst = 1'b0;
        chk("midrst_rvalid", 32'(rd_if.rvalid), 32'd0);
        chk("midrst_rempty", 32'(rempty), 32'd1);
        chk("midrst_rptr", 32'(rptr), 32'd0);

        // Random streaming across the pointer wrap.
        do_reset();
        wrapped = 1'b0;
        for (int c = 0; c < 3000 && consumed.size() < 40; c++) begin
            if (sent.size() < 40 && (wcnt - m_rd) < 16 && $urandom_range(0, 2) != 0)
                push_word(8'($urandom));
            rd_if.rready = 1'($urandom_range(0, 1));
            tick();
        end
        rd_if.rready = 1'b0;
        chk("rand_all_consumed", 32'(consumed.size()), 32'd40);
        for (int i = 0; i < 40; i++)
            chk($sformatf("rand_word%0d", i),
                32'((i < consumed.size()) ? consumed[i] : 8'hxx),
                32'((i < sent.size()) ? sent[i] : 8'hxx));
        chk("rand_wrapped", 32'(wrapped), 32'd1);
        for (int i = 0; i < 3; i++) tick();
        chk("rand_end_rempty", 32'(rempty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
